// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser,
// bit-centre sampling, byte strobe and framing-error strobe.
//
// Ports:
//   clk_in        system clock, rising edge
//   rstn_in       asynchronous active-low reset
//   rx_in         asynchronous serial line, idle high
//   data_out      last correctly received byte
//   valid_out     one-cycle pulse, data_out updated
//   frame_err_out one-cycle pulse, stop bit sampled low
//   busy_out      high while a frame is being received

`ifndef B230400
`define B230400 52
`endif

module uart_rx #(
   parameter int M = `B230400,
   parameter int H = M / 2
) (
   input  logic       clk_in,
   input  logic       rstn_in,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       frame_err_out,
   output logic       busy_out
);

   localparam int CW = $clog2(M);

   localparam logic [CW-1:0] M_LOAD = CW'(M - 1);
   localparam logic [CW-1:0] H_LOAD = CW'(H - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state_q, state_d;
   logic            sync_q;
   logic            rxs_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            tick;
   logic            counting;

   // Two-flop synchroniser, reset to the idle level so that a
   // released reset never looks like a start edge by itself.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         sync_q <= 1'b1;
         rxs_q  <= 1'b1;
      end else begin
         sync_q <= rx_in;
         rxs_q  <= sync_q;
      end
   end

   assign tick     = (cnt_q == '0);
   assign counting = (state_q == S_START) ||
                     (state_q == S_DATA)  ||
                     (state_q == S_STOP);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      if (counting && !tick) begin
         cnt_d = cnt_q - ONE;
      end

      unique case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               cnt_d   = H_LOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               // Line back high at the start-bit centre:
               // treat as noise and drop silently.
               if (rxs_q) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = M_LOAD;
                  bit_d   = 3'd0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = {rxs_q, shift_q[7:1]};
               cnt_d   = M_LOAD;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               // Leave immediately after the stop sample so a
               // following start edge up to half a bit early
               // is still caught.
               if (rxs_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rxs_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_out      = data_q;
   assign valid_out     = valid_q;
   assign frame_err_out = ferr_q;
   assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven checks for uart_rx
// at M=52 plus hand-written corner-case sequences.

module tb_uart_rx;

   logic       clk;
   logic       rstn;
   logic       rx_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       frame_err_out;
   logic       busy_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nvalid = 0;
   int nferr = 0;
   int last_cyc = 0;
   int mon_bad = 0;
   logic prev_v = 1'b0;

   uart_rx #(.M(52)) dut (
      .clk_in        (clk),
      .rstn_in       (rstn),
      .rx_in         (rx_in),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .frame_err_out (frame_err_out),
      .busy_out      (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_out) begin
         nvalid   <= nvalid + 1;
         last_cyc <= cyc;
      end
      if (frame_err_out) nferr <= nferr + 1;
      if (valid_out && frame_err_out) mon_bad <= mon_bad + 1;
      if (valid_out && prev_v) mon_bad <= mon_bad + 1;
      prev_v <= valid_out;
   end

   typedef struct {
      logic [7:0] d;
      int         p;
      logic       stopv;
      int         nbits;
      int         gap;
      int         exp_v;
      int         exp_f;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input int act,
                      input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   // Drives nbits bit periods starting at the current negedge.
   // p is the bit period in hundredths of a cycle.
   task automatic drive(input logic [7:0] d, input int p,
                        input logic stopv, input int nbits);
      logic [7:0] dd;
      dd = d;
      for (int i = 0; i < nbits; i++) begin
         if (i == 0) rx_in = 1'b0;
         else if (i <= 8) rx_in = dd[i-1];
         else rx_in = stopv;
         repeat (((i + 1) * p) / 100 - (i * p) / 100)
            @(negedge clk);
      end
   endtask

   initial begin
      int v0, f0, c0;

      tbl[0]  = '{8'hA3, 5200, 1'b1, 10,  0, 1, 0, 8'hA3};
      tbl[1]  = '{8'h00, 5200, 1'b1, 10,  0, 1, 0, 8'h00};
      tbl[2]  = '{8'hFF, 5200, 1'b1, 10, 30, 1, 0, 8'hFF};
      tbl[3]  = '{8'hA3, 5044, 1'b1, 10,  0, 1, 0, 8'hA3};
      tbl[4]  = '{8'h00, 5044, 1'b1, 10,  0, 1, 0, 8'h00};
      tbl[5]  = '{8'hFF, 5044, 1'b1, 10, 30, 1, 0, 8'hFF};
      tbl[6]  = '{8'hA3, 5356, 1'b1, 10,  0, 1, 0, 8'hA3};
      tbl[7]  = '{8'h00, 5356, 1'b1, 10,  0, 1, 0, 8'h00};
      tbl[8]  = '{8'hFF, 5356, 1'b1, 10, 30, 1, 0, 8'hFF};
      tbl[9]  = '{8'h81, 5200, 1'b0, 11, 30, 0, 1, 8'hFF};
      tbl[10] = '{8'h42, 5200, 1'b1, 10, 30, 1, 0, 8'h42};

      rstn  = 1'b0;
      rx_in = 1'b1;

      // Reset with the line toggling
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rx_in = ~rx_in;
         if (i == 3 || i == 7) begin
            chk("rst_data", data_out, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_ferr", frame_err_out, 0);
            chk("rst_busy", busy_out, 0);
         end
      end
      rx_in = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_data", data_out, 0);
      chk("idle_valid", nvalid, 0);
      chk("idle_busy", busy_out, 0);

      // Single byte with latency
      v0 = nvalid;
      f0 = nferr;
      c0 = cyc;
      drive(8'h55, 5200, 1'b1, 10);
      chk("b55_count", nvalid - v0, 1);
      chk("b55_ferr", nferr - f0, 0);
      chk("b55_data", data_out, 8'h55);
      chk("b55_latency", last_cyc - c0, 497);
      repeat (20) @(negedge clk);

      // Table: back-to-back, skewed baud, framing error
      for (int k = 0; k < 11; k++) begin
         v0 = nvalid;
         f0 = nferr;
         drive(tbl[k].d, tbl[k].p, tbl[k].stopv, tbl[k].nbits);
         chk($sformatf("t%0d_valid", k), nvalid - v0,
             tbl[k].exp_v);
         chk($sformatf("t%0d_ferr", k), nferr - f0,
             tbl[k].exp_f);
         chk($sformatf("t%0d_data", k), data_out,
             tbl[k].exp_data);
         if (!tbl[k].stopv) begin
            chk($sformatf("t%0d_break_busy", k), busy_out, 1);
            rx_in = 1'b1;
            repeat (5) @(negedge clk);
            chk($sformatf("t%0d_rel_busy", k), busy_out, 0);
         end
         rx_in = 1'b1;
         repeat (tbl[k].gap) @(negedge clk);
      end

      // False start
      v0 = nvalid;
      f0 = nferr;
      rx_in = 1'b0;
      repeat (5) @(negedge clk);
      chk("fs_busy_hi", busy_out, 1);
      repeat (5) @(negedge clk);
      rx_in = 1'b1;
      repeat (19) @(negedge clk);
      chk("fs_busy_lo", busy_out, 0);
      chk("fs_valid", nvalid - v0, 0);
      chk("fs_ferr", nferr - f0, 0);
      repeat (10) @(negedge clk);
      drive(8'h3C, 5200, 1'b1, 10);
      chk("fs_next_cnt", nvalid - v0, 1);
      chk("fs_next_data", data_out, 8'h3C);
      repeat (20) @(negedge clk);

      // Reset during data bit 4
      v0 = nvalid;
      f0 = nferr;
      drive(8'hE7, 5200, 1'b1, 5);
      rx_in = 1'b0;
      repeat (26) @(negedge clk);
      chk("mr_busy_pre", busy_out, 1);
      rstn = 1'b0;
      #1;
      chk("mr_busy", busy_out, 0);
      chk("mr_data", data_out, 0);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("mr_valid", nvalid - v0, 0);
      chk("mr_ferr", nferr - f0, 0);
      drive(8'h99, 5200, 1'b1, 10);
      chk("mr_next_cnt", nvalid - v0, 1);
      chk("mr_next_data", data_out, 8'h99);
      chk("mr_next_ferr", nferr - f0, 0);
      repeat (20) @(negedge clk);

      chk("pulse_monitor", mon_bad, 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the tracker's UART transmit path.
- Oversamples the asynchronous rx line with the system clock, resynchronises it, and recovers bytes by sampling at bit centres.
- Presents each recovered byte with a one-cycle valid strobe to downstream tracker logic.
- Flags framing errors.
- Bit timing is generated internally from the same divisor constants used by the transmitter (e.g. the 230400 baud constant).

Parameters:
- M, default `B230400 (52 at 12 MHz): clock cycles per bit, ≥ 4.
- H, default M/2 (integer floor): cycles from detected start edge to the start-bit sample point.

Ports:
- clk_in  input  1  system clock, rising edge.
- rstn_in  input  1  asynchronous active-low reset.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly received byte.
- valid_out  output  1  one-cycle pulse: data_out updated.
- frame_err_out  output  1  one-cycle pulse: stop bit sampled low.
- busy_out  output  1  high while a frame is being received.

Behaviour:
- Interface (already decided): one clock, clk_in; reset rstn_in is asynchronous and active-low. All state is cleared immediately on rstn_in low and released synchronously on clk_in.
- Reset values:
  - data_out = 0x00; valid_out = 0; frame_err_out = 0; busy_out = 0.
  - Synchroniser flops = 1; state = IDLE; bit counter = 0; divide counter = 0.
- Input conditioning: 2-flop synchroniser on rx_in, reset to 1. rxs = second flop output. All logic below uses rxs only; pin-to-rxs latency is 2 cycles.
- Divide counter: width $clog2(M). Reloaded on state entry; counts down and generates a sample tick at 0.
- States and transitions:
  - IDLE: busy_out = 0. First cycle with rxs = 0 is cycle 0: load counter to H-1, go to START.
  - START: busy_out = 1. Tick (cycle H): if rxs = 1, false start, go to IDLE with no output pulse. Else load M-1, bit index = 0, go to DATA.
  - DATA: on each tick (cycles H+M·(k+1), k = 0..7), shift rxs into the shift register LSB first, then reload M-1. After bit 7, go to STOP.
  - STOP: tick at cycle H+9M.
    - rxs = 1: on the next cycle data_out ← shift register and valid_out = 1 for exactly one cycle; go to IDLE.
    - rxs = 0: frame_err_out = 1 for one cycle, data_out unchanged; go to BREAK.
  - BREAK: busy_out = 1. Wait for rxs = 1, then go to IDLE. No new frame is detected until the line has returned high.
- Latency: valid_out rises H+9M+1 cycles after rxs first goes low, i.e. H+9M+3 cycles after the rx_in falling edge.
- Back-to-back frames: IDLE is entered right after the stop sample, so a start edge arriving within half a bit of the nominal stop end is still captured.
- valid_out and frame_err_out are never asserted in the same cycle.
- data_out holds its value until the next valid frame.
- Reset mid-frame: the partial byte is discarded, there is no pulse, and the block is in IDLE on release.
- A glitch on rx_in narrower than 1 cycle may be missed by the synchroniser; this is acceptable.
- rx_in held low at reset release: treated as a start edge on the first cycle. It yields a frame_err_out pulse, then BREAK until the line goes high.

Test Plan:
- Reset state: rstn_in low with rx_in toggling -> all outputs 0; outputs stay 0 with rx_in idle after release.
- Single byte 0x55, M=52: drive 8N1 frame -> exactly one valid_out pulse 497 cycles after the rx_in falling edge; data_out = 0x55; no frame_err_out.
- Back-to-back 0xA3, 0x00, 0xFF with no idle gap, plus a run with the baud clock ±3% off -> three valid_out pulses carrying the correct bytes in order.
- False start: rx_in low for 10 cycles then high -> no pulse; busy_out drops back to 0 by cycle H+3; the next real frame 0x3C is received correctly.
- Framing error: frame 0x81 with stop bit low, line held low 2 bit times -> one frame_err_out pulse; data_out keeps its prior value; busy_out stays high until the line rises; the next frame 0x42 is received.
- Reset mid-frame: assert rstn_in during data bit 4 -> no pulse, busy_out = 0 immediately; after release, frame 0x99 is received correctly.
